ctrl_seq: RTL and testbench

Fetch/decode/execute control sequencer for the 8-bit shared-bus CPU. It drives the control lines of the program counter and its neighbouring registers: PC, MAR, RAM, IR, ACC, B, ALU, OUT and flags. It steps a T-state counter, decodes the IR opcode, and emits one control word per cycle. pc_inc, load_pc and pc_oen feed the PC stage directly.

---
 rtl/ctrl_pkg.sv | 44 ++++
 rtl/ctrl_tcount.sv | 28 ++
 rtl/ctrl_seq.sv | 161 ++++++++++++++++
 tb/tb_ctrl_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the 8-bit shared-bus CPU: opcodes, T-state numbers
// and control-word bit positions.
package ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;

  localparam int CW_PC_INC     = 0;
  localparam int CW_LOAD_PC    = 1;
  localparam int CW_PC_OEN     = 2;
  localparam int CW_MAR_INEN   = 3;
  localparam int CW_RAM_OEN    = 4;
  localparam int CW_RAM_WE     = 5;
  localparam int CW_IR_INEN    = 6;
  localparam int CW_IR_OEN     = 7;
  localparam int CW_ACC_INEN   = 8;
  localparam int CW_ACC_OEN    = 9;
  localparam int CW_B_INEN     = 10;
  localparam int CW_ALU_OEN    = 11;
  localparam int CW_ALU_SUB    = 12;
  localparam int CW_FLAGS_INEN = 13;
  localparam int CW_OUT_INEN   = 14;
  localparam int CW_W          = 15;

  typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/ctrl_tcount.sv
// T-state counter: wraps at NUM_T, freezes while hold is high, and returns to
// T0 on the next edge when restart is high.
module ctrl_tcount #(
  parameter int NUM_T  = 5,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              hold,
  input  logic              restart,
  output logic [STEP_W-1:0] t_state
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      t_state <= '0;
    end else if (hold) begin
      t_state <= t_state;
    end else if (restart || t_state == STEP_W'(NUM_T - 1)) begin
      t_state <= '0;
    end else begin
      t_state <= t_state + STEP_W'(1);
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// Fetch/decode/execute control sequencer. Defining CTRL_SEQ_EARLY_END_EN ends
// each instruction right after its last active step instead of at NUM_T.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int NUM_T  = 5,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              carry,
  input  logic              zero,
  output logic              pc_inc,
  output logic              load_pc,
  output logic              pc_oen,
  output logic              mar_inen,
  output logic              ram_oen,
  output logic              ram_we,
  output logic              ir_inen,
  output logic              ir_oen,
  output logic              acc_inen,
  output logic              acc_oen,
  output logic              b_inen,
  output logic              alu_oen,
  output logic              alu_sub,
  output logic              flags_inen,
  output logic              out_inen,
  output logic              halted,
  output logic [STEP_W-1:0] t_state
);

  cw_t  cw;
  logic halt_set;
  logic restart;

  ctrl_tcount #(.NUM_T(NUM_T), .STEP_W(STEP_W)) u_tcount (
    .clk     (clk),
    .clr     (clr),
    .hold    (halted),
    .restart (restart),
    .t_state (t_state)
  );

  assign halt_set = (t_state == STEP_W'(T2)) && (opcode == OP_HLT) && !halted;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) halted <= 1'b0;
    else if (halt_set) halted <= 1'b1;
  end

`ifdef CTRL_SEQ_EARLY_END_EN
  logic mem_op, alu_op;
  assign mem_op  = (opcode == OP_LDA) || (opcode == OP_STA);
  assign alu_op  = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign restart = ((t_state == STEP_W'(T2)) && !mem_op && !alu_op) ||
                   ((t_state == STEP_W'(T3)) && mem_op) ||
                   ((t_state == STEP_W'(T4)) && alu_op);
`else
  assign restart = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path can
  // infer a latch.
  always_comb begin
    cw = '0;
    case (t_state)
      STEP_W'(T0): begin
        cw[CW_PC_OEN]   = 1'b1;
        cw[CW_MAR_INEN] = 1'b1;
      end
      STEP_W'(T1): begin
        cw[CW_RAM_OEN] = 1'b1;
        cw[CW_IR_INEN] = 1'b1;
        cw[CW_PC_INC]  = 1'b1;
      end
      STEP_W'(T2): begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IR_OEN]   = 1'b1;
            cw[CW_MAR_INEN] = 1'b1;
          end
          OP_LDI: begin
            cw[CW_IR_OEN]   = 1'b1;
            cw[CW_ACC_INEN] = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IR_OEN]  = 1'b1;
            cw[CW_LOAD_PC] = 1'b1;
          end
          OP_JC: begin
            cw[CW_IR_OEN]  = carry;
            cw[CW_LOAD_PC] = carry;
          end
          OP_JZ: begin
            cw[CW_IR_OEN]  = zero;
            cw[CW_LOAD_PC] = zero;
          end
          OP_OUT: begin
            cw[CW_ACC_OEN]  = 1'b1;
            cw[CW_OUT_INEN] = 1'b1;
          end
          default: cw = '0;
        endcase
      end
      STEP_W'(T3): begin
        case (opcode)
          OP_LDA: begin
            cw[CW_RAM_OEN]  = 1'b1;
            cw[CW_ACC_INEN] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RAM_OEN] = 1'b1;
            cw[CW_B_INEN]  = 1'b1;
          end
          OP_STA: begin
            cw[CW_ACC_OEN] = 1'b1;
            cw[CW_RAM_WE]  = 1'b1;
          end
          default: cw = '0;
        endcase
      end
      STEP_W'(T4): begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw[CW_ALU_OEN]    = 1'b1;
          cw[CW_ACC_INEN]   = 1'b1;
          cw[CW_FLAGS_INEN] = 1'b1;
          cw[CW_ALU_SUB]    = (opcode == OP_SUB);
        end
      end
      default: cw = '0;
    endcase
    // clr gates combinationally so the bus is quiet for the whole reset pulse.
    if (clr || halted) cw = '0;
  end

  assign pc_inc     = cw[CW_PC_INC];
  assign load_pc    = cw[CW_LOAD_PC];
  assign pc_oen     = cw[CW_PC_OEN];
  assign mar_inen   = cw[CW_MAR_INEN];
  assign ram_oen    = cw[CW_RAM_OEN];
  assign ram_we     = cw[CW_RAM_WE];
  assign ir_inen    = cw[CW_IR_INEN];
  assign ir_oen     = cw[CW_IR_OEN];
  assign acc_inen   = cw[CW_ACC_INEN];
  assign acc_oen    = cw[CW_ACC_OEN];
  assign b_inen     = cw[CW_B_INEN];
  assign alu_oen    = cw[CW_ALU_OEN];
  assign alu_sub    = cw[CW_ALU_SUB];
  assign flags_inen = cw[CW_FLAGS_INEN];
  assign out_inen   = cw[CW_OUT_INEN];

  a_bus_exclusive: assert property (@(posedge clk) disable iff (clr)
    $onehot0({pc_oen, ram_oen, ir_oen, acc_oen, alu_oen}));
  a_pc_inc_vs_load: assert property (@(posedge clk) disable iff (clr)
    !(pc_inc && load_pc));
  a_ram_we_vs_oen: assert property (@(posedge clk) disable iff (clr)
    !(ram_we && ram_oen));

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: fetch, each execute class, conditional jumps,
// halt, mid-instruction reset, undefined opcode and a random instruction stream.
module tb_ctrl_seq;

`ifdef CTRL_SEQ_EARLY_END_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  // Observed word order: pc_inc .. out_inen, MSB first.
  localparam logic [14:0] PCI  = 15'h4000;
  localparam logic [14:0] LDPC = 15'h2000;
  localparam logic [14:0] PCO  = 15'h1000;
  localparam logic [14:0] MARI = 15'h0800;
  localparam logic [14:0] RAMO = 15'h0400;
  localparam logic [14:0] RAMW = 15'h0200;
  localparam logic [14:0] IRI  = 15'h0100;
  localparam logic [14:0] IRO  = 15'h0080;
  localparam logic [14:0] ACCI = 15'h0040;
  localparam logic [14:0] ACCO = 15'h0020;
  localparam logic [14:0] BI   = 15'h0010;
  localparam logic [14:0] ALUO = 15'h0008;
  localparam logic [14:0] SUBS = 15'h0004;
  localparam logic [14:0] FLGI = 15'h0002;
  localparam logic [14:0] OUTI = 15'h0001;
  localparam logic [14:0] F0   = PCO | MARI;
  localparam logic [14:0] F1   = RAMO | IRI | PCI;

  logic       clk, clr, carry, zero;
  logic [3:0] opcode;
  logic       pc_inc, load_pc, pc_oen, mar_inen, ram_oen, ram_we, ir_inen, ir_oen;
  logic       acc_inen, acc_oen, b_inen, alu_oen, alu_sub, flags_inen, out_inen, halted;
  logic [2:0] t_state;

  int checks = 0;
  int failures = 0;

  ctrl_seq dut (
    .clk(clk), .clr(clr), .opcode(opcode), .carry(carry), .zero(zero),
    .pc_inc(pc_inc), .load_pc(load_pc), .pc_oen(pc_oen), .mar_inen(mar_inen),
    .ram_oen(ram_oen), .ram_we(ram_we), .ir_inen(ir_inen), .ir_oen(ir_oen),
    .acc_inen(acc_inen), .acc_oen(acc_oen), .b_inen(b_inen), .alu_oen(alu_oen),
    .alu_sub(alu_sub), .flags_inen(flags_inen), .out_inen(out_inen),
    .halted(halted), .t_state(t_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] obs();
    return {pc_inc, load_pc, pc_oen, mar_inen, ram_oen, ram_we, ir_inen, ir_oen,
            acc_inen, acc_oen, b_inen, alu_oen, alu_sub, flags_inen, out_inen};
  endfunction

  function automatic int exp_len(input logic [3:0] op);
    if (!EE) return 5;
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  // Sampling point throughout: 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    #1;
    checks++;
    if (obs() !== 15'h0 || halted !== 1'b0 || t_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_hold word=%h halted=%b t=%0d, want 0/0/0", obs(), halted, t_state);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
  endtask

  task automatic check_instr(input string name, input logic [3:0] op, input logic c,
                             input logic z, input logic [14:0] w2, input logic [14:0] w3,
                             input logic [14:0] w4);
    logic [14:0] exp;
    int len;
    opcode = op; carry = c; zero = z;
    len = exp_len(op);
    for (int i = 0; i < len; i++) begin
      case (i)
        0: exp = F0;
        1: exp = F1;
        2: exp = w2;
        3: exp = w3;
        default: exp = w4;
      endcase
      checks++;
      if (obs() !== exp || t_state !== 3'(i)) begin
        failures++;
        $display("FAIL %s T%0d word=%h t=%0d, want word=%h t=%0d", name, i, obs(), t_state, exp, i);
      end
      tick();
    end
    checks++;
    if (t_state !== 3'd0) begin
      failures++;
      $display("FAIL %s_period t=%0d after %0d cycles, want 0", name, t_state, len);
    end
  endtask

  task automatic test_reset();
    opcode = 4'h0; carry = 1'b0; zero = 1'b0;
    do_reset();
    check_instr("nop_fetch", 4'h0, 1'b0, 1'b0, 15'h0, 15'h0, 15'h0);
    check_instr("nop_fetch2", 4'h0, 1'b0, 1'b0, 15'h0, 15'h0, 15'h0);
  endtask

  task automatic test_execute();
    check_instr("add", 4'h2, 1'b0, 1'b0, IRO | MARI, RAMO | BI, ALUO | ACCI | FLGI);
    check_instr("sub", 4'h3, 1'b0, 1'b0, IRO | MARI, RAMO | BI, ALUO | ACCI | FLGI | SUBS);
    check_instr("lda", 4'h1, 1'b0, 1'b0, IRO | MARI, RAMO | ACCI, 15'h0);
    check_instr("sta", 4'h4, 1'b0, 1'b0, IRO | MARI, ACCO | RAMW, 15'h0);
    check_instr("ldi", 4'h5, 1'b0, 1'b0, IRO | ACCI, 15'h0, 15'h0);
    check_instr("jmp", 4'h6, 1'b0, 1'b0, IRO | LDPC, 15'h0, 15'h0);
    check_instr("out", 4'hE, 1'b0, 1'b0, ACCO | OUTI, 15'h0, 15'h0);
  endtask

  task automatic test_cond_jump();
    check_instr("jc_nt", 4'h7, 1'b0, 1'b1, 15'h0, 15'h0, 15'h0);
    check_instr("jc_t",  4'h7, 1'b1, 1'b0, IRO | LDPC, 15'h0, 15'h0);
    check_instr("jz_nt", 4'h8, 1'b1, 1'b0, 15'h0, 15'h0, 15'h0);
    check_instr("jz_t",  4'h8, 1'b0, 1'b1, IRO | LDPC, 15'h0, 15'h0);
  endtask

  task automatic test_halt();
    logic [2:0] frozen;
    frozen = EE ? 3'd0 : 3'd3;
    opcode = 4'hF; carry = 1'b0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs() !== (i == 0 ? F0 : (i == 1 ? F1 : 15'h0)) || halted !== 1'b0) begin
        failures++;
        $display("FAIL hlt_T%0d word=%h halted=%b", i, obs(), halted);
      end
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (halted !== 1'b1 || obs() !== 15'h0 || t_state !== frozen) begin
        failures++;
        $display("FAIL halted_cyc%0d halted=%b word=%h t=%0d, want 1/0/%0d",
                 i, halted, obs(), t_state, frozen);
      end
      tick();
    end
    do_reset();
    checks++;
    if (halted !== 1'b0 || t_state !== 3'd0 || obs() !== F0) begin
      failures++;
      $display("FAIL halt_exit halted=%b t=%0d word=%h, want 0/0/%h", halted, t_state, obs(), F0);
    end
    check_instr("after_halt", 4'h0, 1'b0, 1'b0, 15'h0, 15'h0, 15'h0);
  endtask

  task automatic test_reset_mid_sta();
    opcode = 4'h4;
    tick(); tick(); tick();
    checks++;
    if (t_state !== 3'd3 || obs() !== (ACCO | RAMW)) begin
      failures++;
      $display("FAIL sta_T3 t=%0d word=%h, want 3/%h", t_state, obs(), ACCO | RAMW);
    end
    #1 clr = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0 || obs() !== 15'h0 || t_state !== 3'd0) begin
      failures++;
      $display("FAIL mid_clr ram_we=%b word=%h t=%0d, want 0/0/0", ram_we, obs(), t_state);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if (t_state !== 3'd0 || obs() !== F0) begin
      failures++;
      $display("FAIL mid_clr_release t=%0d word=%h, want 0/%h", t_state, obs(), F0);
    end
  endtask

  task automatic test_random_stream();
    int viol = 0;
    int pulses = 0;
    int cyc;
    bit timed_out = 1'b0;
    check_instr("undef_b", 4'hB, 1'b1, 1'b1, 15'h0, 15'h0, 15'h0);
    for (int n = 0; n < 1000; n++) begin
      opcode = 4'($urandom_range(0, 14));
      carry  = 1'($urandom_range(0, 1));
      zero   = 1'($urandom_range(0, 1));
      cyc = 0;
      do begin
        if (!$onehot0({pc_oen, ram_oen, ir_oen, acc_oen, alu_oen}) ||
            (pc_inc && load_pc) || (ram_we && ram_oen)) viol++;
        if (pc_inc) pulses++;
        tick();
        cyc++;
      end while (t_state !== 3'd0 && cyc < 20);
      if (cyc >= 20) timed_out = 1'b1;
    end
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL stream_timeout instruction did not return to T0 within 20 cycles");
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL stream_invariants violations=%0d, want 0", viol);
    end
    checks++;
    if (pulses != 1000) begin
      failures++;
      $display("FAIL stream_pc_inc pulses=%0d, want 1000", pulses);
    end
  endtask

  initial begin
    clr = 1'b1; opcode = 4'h0; carry = 1'b0; zero = 1'b0;
    tick();
    test_reset();
    test_execute();
    test_cond_jump();
    test_halt();
    test_reset_mid_sta();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
